// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_queue_pkg;

    localparam int                WORD_W           = 32;
    localparam int                DEFAULT_DEPTH    = 4;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {pc, word} entries, with flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is refused when full unless a pop happens the same cycle.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count
);

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en, pop_en;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push_en && !flush) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: single-outstanding memory requests feeding a decode queue, with redirect flush.
// Latency: ack to instr_valid is 1 cycle; zero-wait memory sustains one instruction per cycle.
// Backpressure: instr_ready stalls pops; no request issues unless the queue has room for its result.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_W-1:0] addr_q, addr_d;

    logic              push, pop, issue, wait_ack;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count, occ_after;
    fetch_entry_t      push_entry, head_entry;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (head_entry),
        .count    (fifo_count)
    );

    // Datapath controls: what is pushed/popped and whether a new request goes out.
    always_comb begin
        wait_ack        = (state_q == FS_WAIT) & imem_ack;
        push            = wait_ack & ~redirect & (~fifo_full | pop);
        push_entry.pc   = fetch_pc_q;
        push_entry.word = imem_rdata;
        occ_after       = fifo_count + CW'(push) - CW'(pop);
        // A new request reserves the one slot its result will need.
        issue = ((state_q == FS_IDLE) | wait_ack) & ~redirect
              & (occ_after < CW'(DEPTH));

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        addr_d = addr_q;
        if (issue) addr_d = fetch_pc_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE: begin
                if (issue) state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (imem_ack) begin
                    state_d = issue ? FS_WAIT : FS_IDLE;
                end else if (redirect) begin
                    state_d = FS_DROP;
                end
            end
            FS_DROP: begin
                if (imem_ack) state_d = FS_IDLE;
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin
        imem_req    = (state_q != FS_IDLE);
        imem_addr   = addr_q;
        instr_valid = ~fifo_empty;
        pop         = instr_valid & instr_ready & ~redirect;
        instr       = instr_valid ? head_entry.word : '0;
        instr_pc    = instr_valid ? head_entry.pc   : '0;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, backpressure, redirects, wrap, reset.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    logic manual_mode;
    logic manual_ack;
    int   mem_lat;
    int   wait_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    // Memory model: word contents derived from the address; ack after mem_lat wait cycles.
    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;
    assign imem_ack   = manual_mode ? manual_ack : (imem_req && (wait_cnt >= mem_lat));

    always @(posedge clk) begin
        wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " imem_req"},    {31'd0, imem_req},    32'd0);
        check({tag, " imem_addr"},   imem_addr,            32'd0);
        check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, " instr"},       instr,                32'd0);
        check({tag, " instr_pc"},    instr_pc,             32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        manual_mode = 1'b1;
        manual_ack  = 1'b0;
        mem_lat     = 0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Streaming with zero-wait memory.
        reset       = 1'b1;
        manual_mode = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("stream first req",   {31'd0, imem_req},    32'd1);
        check("stream first addr",  imem_addr,            32'd0);
        check("stream not valid",   {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream valid", {31'd0, instr_valid}, 32'd1);
            check("stream pc",    instr_pc,             32'(4 * i));
            check("stream instr", instr,                exp_word(32'(4 * i)));
        end

        // Backpressure: 3-cycle memory, decode stalled.
        reset       = 1'b0;
        instr_ready = 1'b0;
        mem_lat     = 2;
        tick();
        tick();
        check_reset_outputs("reset2");
        reset = 1'b1;
        tick();
        check("bp first req", {31'd0, imem_req}, 32'd1);
        repeat (23) tick();
        check("bp full valid", {31'd0, instr_valid}, 32'd1);
        check("bp full head",  instr_pc,             32'd0);
        check("bp full no req", {31'd0, imem_req},   32'd0);
        repeat (5) tick();
        check("bp still no req", {31'd0, imem_req}, 32'd0);
        check("bp head instr",   instr,             32'hC0DE_0000);
        mem_lat     = 0;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain valid", {31'd0, instr_valid}, 32'd1);
            check("drain pc",    instr_pc,             32'(4 * i));
            tick();
        end

        // Redirect while the fetch for 0x10 is outstanding.
        reset       = 1'b0;
        manual_mode = 1'b1;
        manual_ack  = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rd req addr0", imem_addr, 32'd0);
        manual_ack  = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd warm pc", instr_pc, 32'(4 * i));
        end
        check("rd pending addr", imem_addr, 32'h10);
        manual_ack  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        check("rd drop req",   {31'd0, imem_req},    32'd1);
        check("rd drop addr",  imem_addr,            32'h10);
        check("rd flushed",    {31'd0, instr_valid}, 32'd0);
        redirect = 1'b0;
        tick();
        check("rd hold addr", imem_addr, 32'h10);
        manual_ack = 1'b1;
        tick();
        check("rd idle req",     {31'd0, imem_req},    32'd0);
        check("rd discard",      {31'd0, instr_valid}, 32'd0);
        manual_ack = 1'b0;
        tick();
        check("rd new req",  {31'd0, imem_req}, 32'd1);
        check("rd new addr", imem_addr,         32'h200);
        manual_ack = 1'b1;
        tick();
        check("rd first valid", {31'd0, instr_valid}, 32'd1);
        check("rd first pc",    instr_pc,             32'h200);
        check("rd first instr", instr,                32'hC0DE_0200);

        // Redirect together with ack and pop while holding two entries.
        instr_ready = 1'b0;
        tick();
        check("rap head pc", instr_pc,  32'h200);
        check("rap addr",    imem_addr, 32'h208);
        redirect    = 1'b1;
        redirect_pc = 32'h340;
        instr_ready = 1'b1;
        manual_ack  = 1'b1;
        tick();
        check("rap flushed",  {31'd0, instr_valid}, 32'd0);
        check("rap instr",    instr,                32'd0);
        check("rap instr_pc", instr_pc,             32'd0);
        check("rap idle",     {31'd0, imem_req},    32'd0);
        redirect   = 1'b0;
        manual_ack = 1'b0;
        tick();
        check("rap new req",  {31'd0, imem_req}, 32'd1);
        check("rap new addr", imem_addr,         32'h340);

        // Misaligned redirect target and address wrap.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        check("wrap drop addr", imem_addr, 32'h340);
        redirect   = 1'b0;
        manual_ack = 1'b1;
        tick();
        check("wrap idle", {31'd0, imem_req}, 32'd0);
        manual_ack = 1'b0;
        tick();
        check("wrap aligned addr", imem_addr, 32'hFFFF_FFFC);
        manual_ack  = 1'b1;
        instr_ready = 1'b0;
        tick();
        check("wrap pc",    instr_pc,  32'hFFFF_FFFC);
        check("wrap instr", instr,     32'h3F21_FFFC);
        check("wrap next",  imem_addr, 32'h0000_0000);

        // Reset in WAIT with three entries queued; ack during reset is ignored.
        tick();
        tick();
        check("mid head pc", instr_pc,          32'hFFFF_FFFC);
        check("mid addr",    imem_addr,         32'h8);
        check("mid req",     {31'd0, imem_req}, 32'd1);
        reset = 1'b0;
        tick();
        check_reset_outputs("mid reset");
        reset      = 1'b1;
        manual_ack = 1'b0;
        tick();
        check("post req",   {31'd0, imem_req},    32'd1);
        check("post addr",  imem_addr,            32'd0);
        check("post empty", {31'd0, instr_valid}, 32'd0);
        manual_ack = 1'b1;
        tick();
        check("post valid", {31'd0, instr_valid}, 32'd1);
        check("post pc",    instr_pc,             32'd0);
        check("post instr", instr,                32'hC0DE_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
